// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch FIFO between Fetch and Decode, flushable on redirect.
// Latency: 1 cycle push-to-output (0 cycles when FETCH_QUEUE_BYPASS_EN is defined and the queue is empty).
// Backpressure: in_ready drops only when full (never depends on out_ready); out_ready is ignored when empty.
//
// Optional feature macro: FETCH_QUEUE_BYPASS_EN (combinational empty-queue bypass).
//
// Ports:
//   clk        system clock, all state on the rising edge
//   rst        asynchronous active-low reset
//   in_valid / in_ready / in_inst / in_pc     push side (Fetch)
//   out_valid / out_ready / out_inst / out_pc pop side (Decode); outputs are 0 when nothing is valid
//   flush      discard every queued entry; dominates a push or pop in the same cycle
//   count      current occupancy
module fetch_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int PC_W   = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_inst,
  input  logic [PC_W-1:0]            in_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_inst,
  output logic [PC_W-1:0]            out_pc,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL_M1 = CNT_W'(DEPTH - 1);

  typedef struct packed {
    logic [DATA_W-1:0] inst;
    logic [PC_W-1:0]   pc;
  } entry_t;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_FULL    = 2'd2
  } status_t;

  entry_t             r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  status_t            r_state;

  status_t            w_state_nxt;
  logic [CNT_W-1:0]   w_count_nxt;
  logic               w_wr;
  logic               w_rd;
  logic               w_bypass_take;
  logic               w_out_vld;
  entry_t             w_head;

  // Flow-control flags come from the status register only, so in_ready has
  // no combinational path from out_ready (no push-through when full).
  assign in_ready = (r_state != ST_FULL);

`ifdef FETCH_QUEUE_BYPASS_EN
  logic w_bypass;
  // Empty queue: hand the incoming entry straight to Decode this cycle.
  assign w_bypass      = (r_state == ST_EMPTY) && in_valid && !flush;
  assign w_bypass_take = w_bypass && out_ready;
`else
  assign w_bypass_take = 1'b0;
`endif

  // A bypassed entry that Decode takes in the same cycle is never stored.
  assign w_wr = in_valid && in_ready && !flush && !w_bypass_take;
  assign w_rd = (r_state != ST_EMPTY) && out_ready && !flush;

  always_comb begin
    w_out_vld = (r_state != ST_EMPTY);
    w_head    = r_mem[r_rd_ptr];
`ifdef FETCH_QUEUE_BYPASS_EN
    if (w_bypass) begin
      w_out_vld = 1'b1;
      w_head    = '{inst: in_inst, pc: in_pc};
    end
`endif
  end

  // Present a NOP (all zero) whenever nothing is valid so stale storage never leaks.
  assign out_valid = w_out_vld;
  assign out_inst  = w_out_vld ? w_head.inst : '0;
  assign out_pc    = w_out_vld ? w_head.pc   : '0;
  assign count     = r_count;

  always_comb begin
    w_count_nxt = r_count;
    if (flush) begin
      w_count_nxt = '0;
    end else begin
      case ({w_wr, w_rd})
        2'b10:   w_count_nxt = r_count + CNT_ONE;
        2'b01:   w_count_nxt = r_count - CNT_ONE;
        default: w_count_nxt = r_count;
      endcase
    end
  end

  // Status tracks occupancy: EMPTY <-> PARTIAL <-> FULL, flush forces EMPTY.
  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_wr) w_state_nxt = ST_PARTIAL;
        end
        ST_PARTIAL: begin
          if (w_wr && !w_rd && (r_count == CNT_FULL_M1))
            w_state_nxt = ST_FULL;
          else if (w_rd && !w_wr && (r_count == CNT_ONE))
            w_state_nxt = ST_EMPTY;
        end
        ST_FULL: begin
          if (w_rd && !w_wr) w_state_nxt = ST_PARTIAL;
        end
        default: w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_EMPTY;
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      if (flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        // DEPTH is a power of two, so natural overflow is the modulo wrap.
        if (w_wr) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        if (w_rd) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
    end
  end

  // Storage needs no reset: an entry is only visible once count covers it.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= '{inst: in_inst, pc: in_pc};
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction prefetch buffer between the Fetch stage and the Decode stage.
- Fetch pushes {instruction, PC} pairs. Decode pops them through a valid/ready handshake.
- Fetch keeps running while Decode is stalled. A branch or jump redirect flushes every queued entry.

Parameters:
- DEPTH, 4: number of entries; power of two, minimum 2.
- DATA_W, 32: instruction width.
- PC_W, 32: PC width stored alongside each instruction.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  Fetch presents a valid instruction.
- in_ready  output  1  queue can accept a push this cycle.
- in_inst  input  DATA_W  instruction word from Fetch.
- in_pc  input  PC_W  address of in_inst.
- out_valid  output  1  head entry is valid for Decode.
- out_ready  input  1  Decode consumes the head this cycle.
- out_inst  output  DATA_W  head instruction.
- out_pc  output  PC_W  head PC.
- flush  input  1  discard all entries (branch/jump taken).
- count  output  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Reset (rst=0, asynchronous):
  - read/write pointers=0, count=0.
  - out_valid=0, in_ready=1, out_inst=0, out_pc=0.
  - Storage contents are don't-care but never visible.
- Push: occurs when in_valid && in_ready at a rising edge. Writes {in_inst,in_pc} to wr_ptr, then wr_ptr increments modulo DEPTH.
- Pop: occurs when out_valid && out_ready at a rising edge. rd_ptr increments modulo DEPTH.
- in_ready = (count < DEPTH).
  - It is registered-state-derived only and never depends on out_ready, so there is no push-through when full.
- out_valid = (count != 0).
- out_inst/out_pc = entry at rd_ptr when count != 0; otherwise 0 (NOP encoding).
- Simultaneous push and pop: count unchanged, both pointers advance.
- Full: count==DEPTH, in_ready=0. An in_valid on that cycle is ignored and Fetch must hold its data.
- Empty: out_valid=0. out_ready is ignored.
- Pointer wrap: when DEPTH-1 increments, the pointer returns to 0. No entry is lost across wrap.
- Latency: an entry pushed in cycle N is visible at the outputs in cycle N+1 (registered storage).
- flush=1 at a rising edge:
  - pointers=0, count=0.
  - Any push or pop in that same cycle is discarded. Flush dominates both.
  - out_valid=0 in the following cycle.
- Internal status state (EMPTY, PARTIAL, FULL), derived from count after each edge:
  - EMPTY->PARTIAL on push without pop.
  - PARTIAL->FULL when count reaches DEPTH.
  - FULL->PARTIAL on pop without push.
  - PARTIAL->EMPTY when count reaches 0.
  - Any state->EMPTY on flush.
- Reset asserted mid-operation: all queued entries are lost immediately and the outputs take their reset values.
- Protocol rule for Fetch: once in_valid=1 with in_ready=0, Fetch holds in_inst/in_pc stable until accepted or until flush.

Optional Feature:
- Macro: FETCH_QUEUE_BYPASS_EN.
- Defined: when count==0, in_valid=1 and flush=0, the queue is bypassed combinationally in the same cycle.
  - out_valid=1, out_inst=in_inst, out_pc=in_pc.
  - If out_ready=1 that cycle, the entry is consumed without being written; count stays 0 and pointers are unchanged.
  - If out_ready=0, the entry is written normally.
- Not defined: strict 1-cycle latency. out_valid never depends combinationally on in_valid.

Test Plan:
- Reset then idle: rst low for 2 cycles, release -> out_valid=0, in_ready=1, count=0, out_inst=0x00000000.
- Fill with out_ready=0: push 0x20080001@0x0, 0x20090002@0x4, 0x200A0003@0x8, 0x200B0004@0xC -> count=4, in_ready=0. A 5th push 0x200C0005 is ignored and count stays 4.
- Drain in order: out_ready=1 after the fill -> out_pc sequence 0x0, 0x4, 0x8, 0xC on consecutive cycles; then out_valid=0, count=0.
- Wrap with concurrent push/pop: hold count=2 while pushing and popping every cycle for 10 cycles -> count stays 2, PCs emerge strictly in order, pointers wrap twice.
- Flush with simultaneous push: count=3, assert flush with in_valid=1 (0xDEADBEEF) -> next cycle count=0, out_valid=0. 0xDEADBEEF never appears at the output.
- Bypass (macro defined): empty queue, in_valid=1, in_inst=0x8C080010, out_ready=1 -> same cycle out_valid=1, out_inst=0x8C080010; next cycle count=0. With the macro undefined -> out_valid=0 that cycle and 1 the next.
